text_console_writer: RTL and testbench



---
 rtl/text_console_writer.sv | 199 +++++++++++++++++++
 tb/tb_text_console_writer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Cursor-driven writer into the character buffer: one cell write per cycle, registered one cycle after handshake.
// Backpressure: in_ready is low for the whole clear sweep (after reset and on FF), high otherwise.
module text_console_writer #(
    parameter int         GRID_ROW   = 5,
    parameter int         GRID_COL   = 10,
    parameter int         ADDR_WIDTH = $clog2(GRID_ROW*GRID_COL),
    parameter logic [6:0] BLANK_CHAR = 7'h20
) (
    input  logic                        clk_pix,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  in_ascii,
    input  logic [3:0]                  colorIndexF,
    input  logic [3:0]                  colorIndexB,
    output logic                        buf_we,
    output logic [ADDR_WIDTH-1:0]       buf_addr,
    output logic [15:0]                 buf_data,
    output logic [$clog2(GRID_COL)-1:0] cur_x,
    output logic [$clog2(GRID_ROW)-1:0] cur_y,
    output logic                        busy
);

    localparam int XW = $clog2(GRID_COL);
    localparam int YW = $clog2(GRID_ROW);
    localparam int N  = GRID_ROW * GRID_COL;
    // One extra count past the last cell marks the sweep as finished.
    localparam int SW = $clog2(N + 1);

    localparam logic [6:0] C_BS = 7'h08;
    localparam logic [6:0] C_LF = 7'h0A;
    localparam logic [6:0] C_FF = 7'h0C;
    localparam logic [6:0] C_CR = 7'h0D;

    typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_sweep;
    logic [SW-1:0]         w_sweep_nxt;
    logic [3:0]            r_clr_fg;
    logic [3:0]            r_clr_bg;
    logic [3:0]            w_clr_fg_nxt;
    logic [3:0]            w_clr_bg_nxt;
    logic                  r_we;
    logic                  w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [15:0]           r_data;
    logic [15:0]           w_data_nxt;
    logic [XW-1:0]         r_x;
    logic [XW-1:0]         w_x_nxt;
    logic [YW-1:0]         r_y;
    logic [YW-1:0]         w_y_nxt;
    logic                  w_hs;
    logic                  w_printable;
    logic                  w_sweep_done;
    logic                  w_col_last;
    logic [YW-1:0]         w_y_inc;

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [XW-1:0] x,
                                                        input logic [YW-1:0] y);
        return ADDR_WIDTH'(y) * ADDR_WIDTH'(GRID_COL) + ADDR_WIDTH'(x);
    endfunction

    assign w_hs         = in_valid & in_ready;
    assign w_printable  = (in_ascii >= 7'h20) && (in_ascii != 7'h7F);
    assign w_sweep_done = (r_sweep == SW'(N));
    assign w_col_last   = (r_x == XW'(GRID_COL - 1));
    assign w_y_inc      = (r_y == YW'(GRID_ROW - 1)) ? '0 : r_y + YW'(1);

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (w_sweep_done) w_state_nxt = S_IDLE;
            S_IDLE:  if (w_hs && !w_printable && in_ascii == C_FF) w_state_nxt = S_CLEAR;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_CLEAR: busy     = 1'b1;
            S_IDLE:  in_ready = 1'b1;
            default: busy     = 1'b1;
        endcase
    end

    always_comb begin
        w_we_nxt     = 1'b0;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_sweep_nxt  = r_sweep;
        w_clr_fg_nxt = r_clr_fg;
        w_clr_bg_nxt = r_clr_bg;
        case (r_state)
            S_CLEAR: begin
                if (!w_sweep_done) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_sweep[ADDR_WIDTH-1:0];
                    w_data_nxt  = {r_clr_bg, r_clr_fg, 1'b0, BLANK_CHAR};
                    w_sweep_nxt = r_sweep + SW'(1);
                end else begin
                    w_sweep_nxt = '0;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                end
            end
            S_IDLE: begin
                if (w_hs) begin
                    if (w_printable) begin
                        w_we_nxt   = 1'b1;
                        w_addr_nxt = cell_addr(r_x, r_y);
                        w_data_nxt = {colorIndexB, colorIndexF, 1'b0, in_ascii};
                        if (w_col_last) begin
                            w_x_nxt = '0;
                            w_y_nxt = w_y_inc;
                        end else begin
                            w_x_nxt = r_x + XW'(1);
                        end
                    end else begin
                        case (in_ascii)
                            C_CR: w_x_nxt = '0;
                            C_LF: w_y_nxt = w_y_inc;
                            C_BS: begin
                                if (r_x != '0) begin
                                    w_x_nxt    = r_x - XW'(1);
                                    w_we_nxt   = 1'b1;
                                    w_addr_nxt = cell_addr(r_x - XW'(1), r_y);
                                    w_data_nxt = {colorIndexB, colorIndexF, 1'b0, BLANK_CHAR};
                                end else if (r_y != '0) begin
                                    w_x_nxt    = XW'(GRID_COL - 1);
                                    w_y_nxt    = r_y - YW'(1);
                                    w_we_nxt   = 1'b1;
                                    w_addr_nxt = cell_addr(XW'(GRID_COL - 1), r_y - YW'(1));
                                    w_data_nxt = {colorIndexB, colorIndexF, 1'b0, BLANK_CHAR};
                                end
                            end
                            C_FF: begin
                                // Cell 0 goes out on the handshake edge so the sweep has no bubble.
                                w_clr_fg_nxt = colorIndexF;
                                w_clr_bg_nxt = colorIndexB;
                                w_we_nxt     = 1'b1;
                                w_addr_nxt   = '0;
                                w_data_nxt   = {colorIndexB, colorIndexF, 1'b0, BLANK_CHAR};
                                w_sweep_nxt  = SW'(1);
                                w_x_nxt      = '0;
                                w_y_nxt      = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_sweep  <= '0;
            r_clr_fg <= '0;
            r_clr_bg <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            r_sweep  <= w_sweep_nxt;
            r_clr_fg <= w_clr_fg_nxt;
            r_clr_bg <= w_clr_bg_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
        end
    end

    assign buf_we   = r_we;
    assign buf_addr = r_addr;
    assign buf_data = r_data;
    assign cur_x    = r_x;
    assign cur_y    = r_y;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed scenarios plus random traffic against a frame-queue reference model.
module tb_text_console_writer;

    localparam int R = 5;
    localparam int C = 10;
    localparam int N = R * C;

    logic        clk_pix = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_ascii = 7'h00;
    logic [3:0]  colorIndexF = 4'h0;
    logic [3:0]  colorIndexB = 4'h0;
    logic        buf_we;
    logic [5:0]  buf_addr;
    logic [15:0] buf_data;
    logic [3:0]  cur_x;
    logic [2:0]  cur_y;
    logic        busy;

    always #5 clk_pix = ~clk_pix;

    text_console_writer #(.GRID_ROW(R), .GRID_COL(C)) dut (
        .clk_pix(clk_pix), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ascii(in_ascii), .colorIndexF(colorIndexF), .colorIndexB(colorIndexB),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    // One frame = what the outputs should show for one cycle.
    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [15:0] data;
        logic        busy;
    } frame_t;

    frame_t cur;
    frame_t q[$];
    int     mx = 0, my = 0;
    int     checks = 0, errors = 0;
    int     n_wr = 0, n_tgt = 0, n_rdy_low = 0;
    logic [15:0] tgt_data = 16'h0020;

    function automatic frame_t mk(logic we, int addr, logic [15:0] data, logic b);
        frame_t f;
        f.we = we; f.addr = 6'(addr); f.data = data; f.busy = b;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_clear(input logic [15:0] d, input int first);
        for (int a = first; a < N; a++) q.push_back(mk(1'b1, a, d, 1'b1));
    endtask

    // Applies the rules to the inputs currently driven, giving the next cycle's frame.
    task automatic model_edge();
        int a;
        frame_t nxt;
        a = int'(in_ascii);
        if (rst) begin
            cur = mk(1'b0, 0, 16'h0, 1'b1);
            q.delete();
            push_clear(16'h0020, 0);
            mx = 0; my = 0;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (!cur.busy && in_valid) begin
            nxt = mk(1'b0, 0, 16'h0, 1'b0);
            if (a >= 32 && a <= 126) begin
                nxt = mk(1'b1, my * C + mx, {colorIndexB, colorIndexF, 1'b0, in_ascii}, 1'b0);
                mx++;
                if (mx == C) begin mx = 0; my = (my + 1) % R; end
            end else if (a == 13) begin
                mx = 0;
            end else if (a == 10) begin
                my = (my + 1) % R;
            end else if (a == 8) begin
                if (mx > 0) begin
                    mx--;
                    nxt = mk(1'b1, my * C + mx, {colorIndexB, colorIndexF, 8'h20}, 1'b0);
                end else if (my > 0) begin
                    mx = C - 1; my--;
                    nxt = mk(1'b1, my * C + mx, {colorIndexB, colorIndexF, 8'h20}, 1'b0);
                end
            end else if (a == 12) begin
                nxt = mk(1'b1, 0, {colorIndexB, colorIndexF, 8'h20}, 1'b1);
                push_clear({colorIndexB, colorIndexF, 8'h20}, 1);
                mx = 0; my = 0;
            end
            cur = nxt;
        end else begin
            cur = mk(1'b0, 0, 16'h0, 1'b0);
        end
    endtask

    task automatic check_all();
        chk("buf_we", 32'(buf_we), 32'(cur.we));
        if (cur.we) begin
            chk("buf_addr", 32'(buf_addr), 32'(cur.addr));
            chk("buf_data", 32'(buf_data), 32'(cur.data));
        end
        chk("cur_x", 32'(cur_x), 32'(mx));
        chk("cur_y", 32'(cur_y), 32'(my));
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("in_ready", 32'(in_ready), 32'(!cur.busy));
        if (buf_we === 1'b1) n_wr++;
        if (buf_we === 1'b1 && buf_data === tgt_data) n_tgt++;
        if (in_ready !== 1'b1) n_rdy_low++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_pix);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [6:0] a, input logic [3:0] f, input logic [3:0] b);
        in_valid = v; in_ascii = a; colorIndexF = f; colorIndexB = b;
        step();
    endtask

    task automatic send(input logic [6:0] a);
        drive(1'b1, a, 4'h0, 4'h0);
    endtask

    task automatic clear_counts(input logic [15:0] d);
        n_wr = 0; n_tgt = 0; n_rdy_low = 0; tgt_data = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic was_busy;
        int   k;
        logic [6:0] ch;

        // Reset for two cycles, then the power-up clear sweep.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_counts(16'h0020);
        for (int i = 0; i < N + 1; i++) step();
        chk("init_clear_writes", 32'(n_wr), 32'(N));
        chk("init_clear_blank", 32'(n_tgt), 32'(N));
        chk("init_ready", 32'(in_ready), 32'd1);

        // First printable character.
        drive(1'b1, 7'h41, 4'hF, 4'h1);
        chk("A_addr", 32'(buf_addr), 32'd0);
        chk("A_data", 32'(buf_data), 32'h1F41);
        chk("A_cur_x", 32'(cur_x), 32'd1);
        drive(1'b0, 7'h41, 4'hF, 4'h1);
        chk("A_we_after", 32'(buf_we), 32'd0);

        // Back-to-back row, then wrap from the last cell to the top.
        send(7'h0D);
        for (int i = 0; i < C; i++) send(7'(8'h30 + i));
        chk("row_cur_x", 32'(cur_x), 32'd0);
        chk("row_cur_y", 32'(cur_y), 32'd1);
        for (int i = 0; i < 3; i++) send(7'h0A);
        for (int i = 0; i < C - 1; i++) send(7'h61);
        send(7'h5A);
        chk("Z_addr", 32'(buf_addr), 32'd49);
        chk("Z_cur_x", 32'(cur_x), 32'd0);
        chk("Z_cur_y", 32'(cur_y), 32'd0);

        // Control codes around (3,2) and backspace at the origin.
        send(7'h0A); send(7'h0A);
        send(7'h61); send(7'h62); send(7'h63);
        send(7'h0D);
        send(7'h0A);
        send(7'h08);
        chk("BS_addr", 32'(buf_addr), 32'd29);
        chk("BS_data", 32'(buf_data), 32'h0020);
        chk("BS_cur_x", 32'(cur_x), 32'd9);
        send(7'h0D);
        for (int i = 0; i < 3; i++) send(7'h0A);
        send(7'h08);
        chk("BS00_we", 32'(buf_we), 32'd0);
        drive(1'b0, 7'h00, 4'h0, 4'h0);

        // Form feed with a character held behind it.
        send(7'h41);
        drive(1'b1, 7'h0C, 4'h2, 4'h7);
        clear_counts(16'h7220);
        n_tgt = (buf_data === 16'h7220 && buf_we === 1'b1) ? 1 : 0;
        n_rdy_low = (in_ready !== 1'b1) ? 1 : 0;
        in_ascii = 7'h42; colorIndexF = 4'h3; colorIndexB = 4'h4;
        k = 0;
        do begin
            was_busy = cur.busy;
            step();
            k++;
        end while (was_busy && k < 60);
        chk("FF_writes", 32'(n_tgt), 32'(N));
        chk("FF_rdy_low", 32'(n_rdy_low), 32'(N));
        chk("B_addr", 32'(buf_addr), 32'd0);
        chk("B_data", 32'(buf_data), 32'h4342);
        drive(1'b0, 7'h00, 4'h0, 4'h0);

        // Reset in the middle of a clear sweep.
        drive(1'b1, 7'h0C, 4'h2, 4'h7);
        in_valid = 1'b0;
        k = 0;
        while (!(cur.we && cur.addr == 6'd20) && k < 60) begin step(); k++; end
        chk("mid_clear_addr", 32'(buf_addr), 32'd20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_counts(16'h0020);
        for (int i = 0; i < N + 1; i++) step();
        chk("rst_clear_writes", 32'(n_wr), 32'(N));
        chk("rst_clear_blank", 32'(n_tgt), 32'(N));

        // Random traffic, weighted towards control codes, with rare resets.
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0: ch = 7'h0D;
                1: ch = 7'h0A;
                2: ch = 7'h08;
                3: ch = ($urandom_range(0, 7) == 0) ? 7'h0C : 7'($urandom_range(0, 127));
                default: ch = 7'($urandom_range(32, 126));
            endcase
            rst = ($urandom_range(0, 249) == 0);
            drive($urandom_range(0, 3) != 0, ch, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        rst = 1'b0;
        drive(1'b0, 7'h00, 4'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
